// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address/instruction widths, fetch FSM states,
// and the {instr, pc} entry carried from fetch to decode.
package cpu_pkg;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 32;
    localparam int FQ_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO with synchronous clear; slot0 is always the head so the
// output needs no read mux.
module fetch_queue #(
    parameter int ENTRY_W = 40
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] head_o,
    output logic [1:0]         count_o
);

    logic [ENTRY_W-1:0] slot0_q;
    logic [ENTRY_W-1:0] slot1_q;
    logic [1:0]         count_q;
    logic               pop_en;

    assign pop_en  = pop_i && (count_q != 2'd0);
    assign valid_o = (count_q != 2'd0);
    assign head_o  = slot0_q;
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else begin
            case ({push_i, pop_en})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= push_data_i;
                    else                 slot1_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: shift and append, count unchanged.
                    if (count_q == 2'd2) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data_i;
                    end else begin
                        slot0_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues one memory read at a time for the current PC,
// queues {instr, pc} for decode, and pulses pc_advance_out on accepted data.
module fetch_stage #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int DEPTH   = cpu_pkg::FQ_DEPTH
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance_out,
    input  logic               flush_in,
    output logic               mem_req_out,
    output logic [ADDR_W-1:0]  mem_addr_out,
    input  logic               mem_ack_in,
    input  logic [INSTR_W-1:0] mem_rdata_in,
    output logic               instr_valid_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc_out,
    input  logic               decode_ready_in
);

    import cpu_pkg::*;

    fetch_state_t              state_q;
    logic                      mem_req_q;
    logic [ADDR_W-1:0]         mem_addr_q;
    logic [1:0]                q_count;
    logic                      q_push;
    logic                      q_pop;
    logic [INSTR_W+ADDR_W-1:0] q_head;

    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = mem_addr_q;

    // Data is accepted only in WAIT without a flush; gated so reset never pulses it.
    assign pc_advance_out = !rst_in && (state_q == S_WAIT) && mem_ack_in && !flush_in;
    assign q_push         = pc_advance_out;
    assign q_pop          = instr_valid_out && decode_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (int'(q_count) < DEPTH && !flush_in) begin
                        mem_addr_q <= pc_in;
                        mem_req_q  <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_in) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (flush_in) begin
                        state_q   <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (mem_ack_in) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    fetch_queue #(
        .ENTRY_W(INSTR_W + ADDR_W)
    ) u_queue (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_i     (q_push),
        .push_data_i({mem_rdata_in, mem_addr_q}),
        .pop_i      (q_pop),
        .clear_i    (flush_in),
        .valid_o    (instr_valid_out),
        .head_o     (q_head),
        .count_o    (q_count)
    );

    assign instr_out    = q_head[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc_out = q_head[ADDR_W-1:0];

endmodule
